// File: rtl/adam_axil_sram.sv
// rtl/adam_axil_sram.sv - AXI-Lite slave SRAM with byte strobes, one outstanding transaction, pause handshake.
// Optional: define ADAM_AXIL_SRAM_BOUNDS_EN to answer offsets >= SIZE with SLVERR instead of aliasing.
module adam_axil_sram #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    SIZE       = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      srst,
    input  logic                      pause_req,
    output logic                      pause_ack,
    input  logic [ADDR_WIDTH-1:0]     axil_aw_addr_i,
    input  logic [2:0]                axil_aw_prot_i,
    input  logic                      axil_aw_valid_i,
    output logic                      axil_aw_ready_o,
    input  logic [DATA_WIDTH-1:0]     axil_w_data_i,
    input  logic [DATA_WIDTH/8-1:0]   axil_w_strb_i,
    input  logic                      axil_w_valid_i,
    output logic                      axil_w_ready_o,
    output logic [1:0]                axil_b_resp_o,
    output logic                      axil_b_valid_o,
    input  logic                      axil_b_ready_i,
    input  logic [ADDR_WIDTH-1:0]     axil_ar_addr_i,
    input  logic [2:0]                axil_ar_prot_i,
    input  logic                      axil_ar_valid_i,
    output logic                      axil_ar_ready_o,
    output logic [DATA_WIDTH-1:0]     axil_r_data_o,
    output logic [1:0]                axil_r_resp_o,
    output logic                      axil_r_valid_o,
    input  logic                      axil_r_ready_i
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH      = SIZE / STRB_WIDTH;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam int MSB        = $clog2(SIZE);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR_RESP = 2'd1;
    localparam logic [1:0] S_RD_RESP = 2'd2;
    localparam logic [1:0] S_PAUSED  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [1:0]            b_resp_q, b_resp_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] aw_off, ar_off;
    logic [MSB-LSB-1:0]    aw_idx, ar_idx;
    logic                  aw_oob, ar_oob;
    logic                  idle_open, wr_fire, rd_fire;
    logic                  unused_ok;

    assign aw_off = axil_aw_addr_i - BASE_ADDR;
    assign ar_off = axil_ar_addr_i - BASE_ADDR;
    assign aw_idx = aw_off[MSB-1:LSB];
    assign ar_idx = ar_off[MSB-1:LSB];

`ifdef ADAM_AXIL_SRAM_BOUNDS_EN
    assign aw_oob = (aw_off >= ADDR_WIDTH'(SIZE));
    assign ar_oob = (ar_off >= ADDR_WIDTH'(SIZE));
`else
    assign aw_oob = 1'b0;
    assign ar_oob = 1'b0;
`endif

    assign unused_ok = ^{axil_aw_prot_i, axil_ar_prot_i, aw_off, ar_off};

    // Nothing is accepted while any reset is active or a pause is being requested.
    assign idle_open = (state_q == S_IDLE) && rst_n && !srst && !pause_req;
    assign wr_fire   = idle_open && axil_aw_valid_i && axil_w_valid_i;
    assign rd_fire   = idle_open && axil_ar_valid_i && !(axil_aw_valid_i && axil_w_valid_i);

    assign axil_aw_ready_o = wr_fire;
    assign axil_w_ready_o  = wr_fire;
    assign axil_ar_ready_o = rd_fire;
    assign axil_b_valid_o  = (state_q == S_WR_RESP);
    assign axil_r_valid_o  = (state_q == S_RD_RESP);
    assign pause_ack       = (state_q == S_PAUSED);
    assign axil_b_resp_o   = b_resp_q;
    assign axil_r_resp_o   = r_resp_q;
    assign axil_r_data_o   = r_data_q;

    always_comb begin
        state_d  = state_q;
        b_resp_d = b_resp_q;
        r_resp_d = r_resp_q;
        r_data_d = r_data_q;
        case (state_q)
            S_IDLE: begin
                if (pause_req) begin
                    state_d = S_PAUSED;
                end else if (wr_fire) begin
                    state_d  = S_WR_RESP;
                    b_resp_d = aw_oob ? 2'b10 : 2'b00;
                end else if (rd_fire) begin
                    state_d  = S_RD_RESP;
                    r_resp_d = ar_oob ? 2'b10 : 2'b00;
                    r_data_d = ar_oob ? '0 : mem_q[ar_idx];
                end
            end
            S_WR_RESP: if (axil_b_ready_i) state_d = pause_req ? S_PAUSED : S_IDLE;
            S_RD_RESP: if (axil_r_ready_i) state_d = pause_req ? S_PAUSED : S_IDLE;
            S_PAUSED:  if (!pause_req)     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            b_resp_q <= 2'b00;
            r_resp_q <= 2'b00;
            r_data_q <= '0;
        end else if (srst) begin
            state_q  <= S_IDLE;
            b_resp_q <= 2'b00;
            r_resp_q <= 2'b00;
            r_data_q <= '0;
        end else begin
            state_q  <= state_d;
            b_resp_q <= b_resp_d;
            r_resp_q <= r_resp_d;
            r_data_q <= r_data_d;
        end
    end

    // Storage is deliberately left out of reset so contents survive rst_n and srst.
    always_ff @(posedge clk) begin
        if (wr_fire && !aw_oob) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (axil_w_strb_i[i]) mem_q[aw_idx][8*i +: 8] <= axil_w_data_i[8*i +: 8];
            end
        end
    end
endmodule
